wdf_sample_collector: RTL and testbench

WDF_SAMPLE_COLLECTOR -- requirements
Module: wdf_sample_collector

---
 rtl/wdf_collector_pkg.sv | 19 +
 rtl/wdf_sync_fifo.sv | 61 ++++++
 rtl/wdf_sample_collector.sv | 124 ++++++++++++
 tb/tb_wdf_sample_collector.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wdf_collector_pkg.sv
// Shared types and constants for the WDF sample collector.
// Holds the run state encoding and counter saturation helpers.
`timescale 1ns/1ps
package wdf_collector_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == CNT_MAX) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/wdf_sync_fifo.sv
// Synchronous FIFO with head-of-queue output and synchronous clear.
// A read in the same cycle as a full-state write frees the slot first.
`timescale 1ns/1ps
module wdf_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   import wdf_collector_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] P_ONE = 1;
   localparam logic [AW:0] C_ONE = 1;
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             rd_ok;
   logic             wr_ok;

   assign empty   = (count == '0);
   assign full    = (count == C_FULL);
   assign rd_ok   = rd_en && !empty;
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy tracking; clear empties the buffer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + P_ONE;
         if (rd_ok) rd_ptr <= rd_ptr + P_ONE;
         if (wr_ok && !rd_ok) count <= count + C_ONE;
         else if (rd_ok && !wr_ok) count <= count - C_ONE;
      end
   end

   // Storage array; contents are meaningless while empty.
   always_ff @(posedge clk) begin
      if (wr_ok && !clear) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/wdf_sample_collector.sv
// Captures a fixed-length run of DUT samples into a FIFO for a reader,
// tracking accepted, dropped and clipped counts plus peak magnitude.
`timescale 1ns/1ps
module wdf_sample_collector #(
   parameter int          DATA_WIDTH    = 16,
   parameter logic [31:0] TOTAL_SAMPLES = 32'd1024,
   parameter int          FIFO_DEPTH    = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           sample_count,
   output logic [31:0]           drop_count,
   output logic [31:0]           clip_count,
   output logic [DATA_WIDTH-1:0] peak_abs
);
   import wdf_collector_pkg::*;

   localparam logic [DATA_WIDTH-1:0] MAXV = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   state_t                state;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  clear;
   logic                  take;
   logic                  rd_en;
   logic                  drop;
   logic                  is_clip;
   logic [DATA_WIDTH-1:0] abs_val;
   logic [31:0]           sc_next;

   assign clear     = start && (state == S_IDLE || state == S_DONE);
   assign take      = (state == S_CAPTURE) && in_valid;
   assign out_valid = !fifo_empty;
   assign rd_en     = out_valid && out_ready;
   assign drop      = take && fifo_full && !rd_en;
   assign is_clip   = (in_data == MAXV) || (in_data == MINV);
   assign sc_next   = sat_inc(sample_count);

   // Magnitude of the incoming sample; the most-negative code saturates.
   always_comb begin
      abs_val = in_data;
      if (in_data == MINV) abs_val = MAXV;
      else if (in_data[DATA_WIDTH-1]) abs_val = ~in_data + 1'b1;
   end

   wdf_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .wr_en   (take),
      .wr_data (in_data),
      .rd_en   (rd_en),
      .rd_data (out_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Run control FSM with registered status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state <= S_CAPTURE;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            S_CAPTURE: begin
               if (in_valid && sc_next == TOTAL_SAMPLES) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (fifo_empty) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Run statistics, cleared when a new run starts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sample_count <= '0;
         drop_count   <= '0;
         clip_count   <= '0;
         peak_abs     <= '0;
      end else if (clear) begin
         sample_count <= '0;
         drop_count   <= '0;
         clip_count   <= '0;
         peak_abs     <= '0;
      end else if (take) begin
         sample_count <= sc_next;
         if (drop) drop_count <= sat_inc(drop_count);
         if (is_clip) clip_count <= sat_inc(clip_count);
         if (abs_val > peak_abs) peak_abs <= abs_val;
      end
   end

endmodule

// File: tb/tb_wdf_sample_collector.sv
// Scoreboard bench: two collectors (8-sample and 20-sample runs),
// expected outputs queued at stimulus time and popped by monitors.
`timescale 1ns/1ps
module tb_wdf_sample_collector;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        sa = 0, va = 0, ra = 0;
   logic [15:0] da = '0;
   logic        ova, busya, donea;
   logic [15:0] oda, pka;
   logic [31:0] sca, dca, cca;

   logic        sb = 0, vb = 0, rb = 0;
   logic [15:0] db = '0;
   logic        ovb, busyb, doneb;
   logic [15:0] odb, pkb;
   logic [31:0] scb, dcb, ccb;

   int checks = 0;
   int errors = 0;
   logic [15:0] qa[$];
   logic [15:0] qb[$];

   wdf_sample_collector #(
      .DATA_WIDTH(16), .TOTAL_SAMPLES(32'd8), .FIFO_DEPTH(16)
   ) u_a (
      .clk(clk), .reset_n(reset_n), .start(sa), .in_valid(va),
      .in_data(da), .out_valid(ova), .out_ready(ra), .out_data(oda),
      .busy(busya), .done(donea), .sample_count(sca),
      .drop_count(dca), .clip_count(cca), .peak_abs(pka)
   );

   wdf_sample_collector #(
      .DATA_WIDTH(16), .TOTAL_SAMPLES(32'd20), .FIFO_DEPTH(16)
   ) u_b (
      .clk(clk), .reset_n(reset_n), .start(sb), .in_valid(vb),
      .in_data(db), .out_valid(ovb), .out_ready(rb), .out_data(odb),
      .busy(busyb), .done(doneb), .sample_count(scb),
      .drop_count(dcb), .clip_count(ccb), .peak_abs(pkb)
   );

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor A: a transfer happens at the next rising edge.
   always @(negedge clk) begin
      if (reset_n && ova && ra) begin
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_extra got %0h exp none", oda);
         end else begin
            chk("a_data", {16'h0, oda}, {16'h0, qa.pop_front()});
         end
      end
   end

   // Monitor B.
   always @(negedge clk) begin
      if (reset_n && ovb && rb) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_extra got %0h exp none", odb);
         end else begin
            chk("b_data", {16'h0, odb}, {16'h0, qb.pop_front()});
         end
      end
   end

   task automatic wait_done_a();
      int n = 0;
      while (!donea && n < 100) begin
         tick();
         n++;
      end
      chk("a_done", {31'h0, donea}, 32'd1);
   endtask

   task automatic wait_done_b();
      int n = 0;
      while (!doneb && n < 100) begin
         tick();
         n++;
      end
      chk("b_done", {31'h0, doneb}, 32'd1);
   endtask

   function automatic logic [15:0] bval(int k);
      return 16'(k * 37 + 1);
   endfunction

   logic [15:0] d1[8];
   logic [15:0] d2[8];

   initial begin
      d1 = '{16'h7FFF, 16'h8000, 16'h0005, 16'hFFF9,
             16'h0064, 16'hFF38, 16'h0003, 16'h0000};
      d2 = '{16'h0001, 16'hFFFE, 16'h0003, 16'hFFFC,
             16'h0005, 16'hFFFA, 16'h0007, 16'hFFF8};

      repeat (3) tick();
      chk("rst_ova", {31'h0, ova}, 32'd0);
      chk("rst_oda", {16'h0, oda}, 32'd0);
      chk("rst_busy", {31'h0, busya}, 32'd0);
      chk("rst_done", {31'h0, donea}, 32'd0);
      chk("rst_sc", sca, 32'd0);
      chk("rst_dc", dca, 32'd0);
      chk("rst_cc", cca, 32'd0);
      chk("rst_pk", {16'h0, pka}, 32'd0);
      reset_n = 1'b1;
      tick();

      // A run 1: 8 samples streamed straight through, clip cases.
      ra = 1;
      sa = 1;
      tick();
      sa = 0;
      chk("a1_busy", {31'h0, busya}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         va = 1;
         da = d1[i];
         qa.push_back(d1[i]);
         tick();
      end
      va = 0;
      chk("a1_sc", sca, 32'd8);
      chk("a1_dc", dca, 32'd0);
      chk("a1_cc", cca, 32'd2);
      chk("a1_pk", {16'h0, pka}, 32'h7FFF);
      wait_done_a();
      chk("a1_left", qa.size(), 32'd0);

      // A run 2: restart from DONE clears statistics.
      sa = 1;
      tick();
      sa = 0;
      chk("a2_clr_sc", sca, 32'd0);
      chk("a2_clr_done", {31'h0, donea}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         va = 1;
         da = d2[i];
         qa.push_back(d2[i]);
         tick();
      end
      va = 0;
      chk("a2_cc", cca, 32'd0);
      chk("a2_pk", {16'h0, pka}, 32'd8);
      wait_done_a();
      chk("a2_left", qa.size(), 32'd0);

      // B run 1: reader stalled, 4 of 20 dropped.
      rb = 0;
      sb = 1;
      tick();
      sb = 0;
      for (int i = 0; i < 20; i++) begin
         vb = 1;
         db = bval(i);
         if (i < 16) qb.push_back(bval(i));
         tick();
      end
      vb = 0;
      chk("b1_dc", dcb, 32'd4);
      chk("b1_sc", scb, 32'd20);
      chk("b1_busy", {31'h0, busyb}, 32'd1);
      chk("b1_hold", {16'h0, odb}, {16'h0, bval(0)});
      tick();
      chk("b1_hold2", {16'h0, odb}, {16'h0, bval(0)});
      rb = 1;
      wait_done_b();
      chk("b1_left", qb.size(), 32'd0);

      // B run 2: ignored start mid-capture, read+write while full.
      rb = 0;
      sb = 1;
      tick();
      sb = 0;
      for (int i = 0; i < 20; i++) begin
         sb = (i == 8);
         rb = (i >= 16);
         vb = 1;
         db = bval(i + 100);
         qb.push_back(bval(i + 100));
         tick();
         if (i == 9) chk("b2_nostart", scb, 32'd10);
         if (i == 16) begin
            chk("b2_full_dc", dcb, 32'd0);
            chk("b2_full_sc", scb, 32'd17);
         end
      end
      sb = 0;
      vb = 0;
      wait_done_b();
      chk("b2_dc", dcb, 32'd0);
      chk("b2_left", qb.size(), 32'd0);

      // B run 3: reset in DRAIN with 5 samples buffered.
      rb = 0;
      sb = 1;
      tick();
      sb = 0;
      for (int i = 0; i < 20; i++) begin
         vb = 1;
         db = bval(i + 200);
         if (i < 16) qb.push_back(bval(i + 200));
         tick();
      end
      vb = 0;
      rb = 1;
      repeat (11) tick();
      rb = 0;
      chk("b3_left5", qb.size(), 32'd5);
      chk("b3_busy", {31'h0, busyb}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("b3_ov", {31'h0, ovb}, 32'd0);
      chk("b3_od", {16'h0, odb}, 32'd0);
      chk("b3_busy0", {31'h0, busyb}, 32'd0);
      chk("b3_done0", {31'h0, doneb}, 32'd0);
      chk("b3_sc", scb, 32'd0);
      chk("b3_dc", dcb, 32'd0);
      chk("b3_pk", {16'h0, pkb}, 32'd0);
      qb.delete();
      tick();
      reset_n = 1'b1;
      repeat (2) tick();
      chk("b3_idle_ov", {31'h0, ovb}, 32'd0);
      chk("b3_idle_busy", {31'h0, busyb}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
